futaba_scan_ctl: RTL
====================

Name: futaba_scan_ctl

Overview:
Grid-scan scheduler that feeds the Futaba VFD serial driver. It holds a double-buffered frame store of segment patterns, one word per grid. On every driver demand it presents the next {grid index, segment pattern} word. At frame boundaries it commits host updates to the frame store and to brightness, so the display never tears.

Parameters:
GRIDS, 20, number of grids scanned per frame (2..20)
SEGW, 76, segment bits per grid word
BRIGHT_RST, 7'd48, blanking compare value loaded at reset

Ports:
C  input  1  clock; all logic on posedge C
R  input  1  synchronous active-high reset
DemandY  input  1  single-cycle request from the driver for the next word
Data  output  81  {grid index [80:76], segment pattern [75:0]} to driver
BK  output  7  blanking compare value to driver
WrE  input  1  host write strobe, frame-store word
WrAddr  input  5  grid index to write
WrData  input  SEGW  segment pattern to write
SwapReq  input  1  host request: make the written bank visible
SwapPend  output  1  swap accepted, not yet committed
Bright  input  7  requested blanking compare value
Enable  input  1  0 = output blank segments; scanning continues
FrameTick  output  1  one-cycle pulse when the scan wraps to grid 0

Behaviour:
- Reset (R=1 at posedge C): grid=0, active bank=0, Valid=0, SwapPend=0, FrameTick=0, BK=BRIGHT_RST, Data={5'd0, 76'd0}. Frame-store contents are not reset.
- Storage: two banks of GRIDS x SEGW. Host writes always target the inactive bank. Writes with WrAddr >= GRIDS are ignored.
- Scan, on a cycle with DemandY=1:
  - If grid == GRIDS-1: grid <= 0 and FrameTick=1 on the next cycle (the wrap event).
  - Otherwise: grid <= grid+1.
  - DemandY is ignored while R=1.
- Data is registered and updated exactly 1 cycle after DemandY.
  - Data[80:76] = new grid index.
  - Data[75:0] = active_bank[new grid] when Valid=1 and Enable=1; otherwise 0.
  - Data holds between demands.
  - The driver samples Data no earlier than 2 cycles after its DemandY pulse.
- Swap:
  - SwapReq=1 sets SwapPend=1.
  - At the next wrap event: bank select toggles, Valid<=1, SwapPend<=0.
  - A SwapReq in the same cycle as a wrapping DemandY is honoured at that wrap: the grid-0 word is read from the new bank, and SwapPend never rises (stays 0).
  - SwapReq while SwapPend=1 has no further effect.
- Write/swap collision: a write in the same cycle as a swap commit lands in the pre-swap inactive bank, i.e. it becomes visible immediately from the next read.
- Brightness:
  - Bright is sampled at each wrap event.
  - BK <= min(Bright, 95).
  - BK never changes mid-frame.
- Enable is sampled per word: a change affects the next Data update only.
- Back-to-back DemandY (consecutive cycles) advances one grid per cycle. There is no stall or backpressure.
- Reset mid-frame or mid-swap: the pending swap is discarded, Valid=0, and scanning restarts at grid 0.

Test Plan:
1. Reset, then 3 DemandY pulses spaced 200 cycles apart -> Data[80:76] = 1, 2, 3, each updated 1 cycle after its pulse; Data[75:0] = 0 (Valid=0); BK = 48.
2. Write patterns 76'h1<<k to bank addresses k=0..19, SwapReq, run 20 DemandY -> SwapPend=1 until the 19->0 wrap; FrameTick pulses once; the next frame shows pattern 1<<k at grid k.
3. Bright=7'd120 set mid-frame -> BK stays at its old value until the wrap, then becomes 95. Bright=10 -> BK=10 after the next wrap.
4. SwapReq in the same cycle as the wrapping DemandY -> grid-0 word comes from the new bank; SwapPend stays 0.
5. Enable=0 for grids 4..6 -> those Data words have segments 0 with correct grid indices; patterns reappear at grid 7 once Enable=1.
6. Assert R while SwapPend=1 at grid 9 -> Data={0,0}, SwapPend=0, BK=48; the next DemandY gives grid 1. A write to WrAddr=25 leaves both banks unchanged.

Source files
------------

// File: rtl/futaba_scan_ctl.sv
// Grid-scan scheduler for the Futaba VFD driver: double-buffered frame store, tear-free commits at frame wrap.
// Latency: Data is registered and updated one cycle after each DemandY pulse; FrameTick follows the wrap by one cycle.
// Backpressure: none; every DemandY advances exactly one grid, and back-to-back demands advance one grid per cycle.
module futaba_scan_ctl #(
  parameter int          GRIDS      = 20,
  parameter int          SEGW       = 76,
  parameter logic [6:0]  BRIGHT_RST = 7'd48
) (
  input  logic              C,
  input  logic              R,
  input  logic              DemandY,
  output logic [SEGW+4:0]   Data,
  output logic [6:0]        BK,
  input  logic              WrE,
  input  logic [4:0]        WrAddr,
  input  logic [SEGW-1:0]   WrData,
  input  logic              SwapReq,
  output logic              SwapPend,
  input  logic [6:0]        Bright,
  input  logic              Enable,
  output logic              FrameTick
);

  // Last grid index of a frame, and the grid count widened so that
  // out-of-range host addresses (up to 31) compare without truncation.
  localparam logic [4:0] LAST_GRID = 5'(GRIDS - 1);
  localparam logic [5:0] GRID_CNT  = 6'(GRIDS);
  localparam logic [6:0] BK_MAX    = 7'd95;

  // Swap handshake: a request waits in SW_PEND until the next wrap.
  typedef enum logic {
    SW_IDLE = 1'b0,
    SW_PEND = 1'b1
  } swap_state_t;

  // Frame store: two banks, one word per grid. Not reset.
  logic [SEGW-1:0] r_mem [2][GRIDS];

  logic            r_bank;
  logic            r_valid;
  logic [4:0]      r_grid;
  logic [6:0]      r_bk;
  logic            r_tick;
  logic [SEGW+4:0] r_data;
  swap_state_t     r_swap_st;

  logic            w_adv;
  logic            w_wrap;
  logic            w_commit;
  logic [4:0]      w_grid_nxt;
  logic            w_bank_nxt;
  logic            w_valid_nxt;
  logic [SEGW-1:0] w_seg;
  logic [6:0]      w_bk_clip;
  logic            w_wr_ok;
  swap_state_t     w_swap_nxt;

  // A demand is only honoured outside reset; the wrap is a demand at the last grid.
  assign w_adv      = DemandY && !R;
  assign w_wrap     = w_adv && (r_grid == LAST_GRID);
  assign w_grid_nxt = (r_grid == LAST_GRID) ? 5'd0 : (r_grid + 5'd1);

  // Bank select and valid as they will be after this cycle, so the grid-0
  // word of a committing wrap is fetched from the newly visible bank.
  assign w_bank_nxt  = w_commit ? ~r_bank : r_bank;
  assign w_valid_nxt = w_commit ? 1'b1 : r_valid;

  // Brightness is clipped to the driver's usable compare range.
  assign w_bk_clip = (Bright > BK_MAX) ? BK_MAX : Bright;

  // Host writes beyond the scanned grids are dropped rather than aliased.
  assign w_wr_ok = WrE && ({1'b0, WrAddr} < GRID_CNT);

  // Swap FSM next-state: commit at the wrap if a request is pending or arrives with it.
  always_comb begin
    w_swap_nxt = r_swap_st;
    w_commit   = 1'b0;
    case (r_swap_st)
      SW_IDLE: begin
        if (w_wrap && SwapReq) begin
          w_commit = 1'b1;
        end else if (SwapReq) begin
          w_swap_nxt = SW_PEND;
        end
      end
      SW_PEND: begin
        if (w_wrap) begin
          w_commit   = 1'b1;
          w_swap_nxt = SW_IDLE;
        end
      end
      default: begin
        w_swap_nxt = SW_IDLE;
      end
    endcase
  end

  // Swap FSM state register; reset discards any pending swap.
  always_ff @(posedge C) begin
    if (R) begin
      r_swap_st <= SW_IDLE;
    end else begin
      r_swap_st <= w_swap_nxt;
    end
  end

  // Segment word for the grid about to be presented; blank until a bank has been committed or while disabled.
  always_comb begin
    w_seg = '0;
    if (w_valid_nxt && Enable) begin
      w_seg = r_mem[w_bank_nxt][w_grid_nxt];
    end
  end

  // Host writes always land in the bank that is inactive before this cycle's commit.
  always_ff @(posedge C) begin
    if (w_wr_ok) begin
      r_mem[~r_bank][WrAddr] <= WrData;
    end
  end

  // Scan position, bank select, valid flag and frame tick.
  always_ff @(posedge C) begin
    if (R) begin
      r_grid  <= 5'd0;
      r_bank  <= 1'b0;
      r_valid <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (w_adv) begin
        r_grid <= w_grid_nxt;
      end
      r_bank  <= w_bank_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Brightness only moves at a frame boundary so a frame is never split across two levels.
  always_ff @(posedge C) begin
    if (R) begin
      r_bk <= BRIGHT_RST;
    end else if (w_wrap) begin
      r_bk <= w_bk_clip;
    end
  end

  // Output word register; holds between demands.
  always_ff @(posedge C) begin
    if (R) begin
      r_data <= '0;
    end else if (w_adv) begin
      r_data <= {w_grid_nxt, w_seg};
    end
  end

  assign Data      = r_data;
  assign BK        = r_bk;
  assign SwapPend  = (r_swap_st == SW_PEND);
  assign FrameTick = r_tick;

endmodule
